// File: rtl/cr_prefix_attach_mem_arb.sv
// Read-port arbiter for one prefix attach descriptor memory: engine bursts vs CSR single reads,
// with yield/stall handling and fixed-latency return tagging.
//
// state | meaning
// IDLE  | no transaction; arbitrate pending requests (round-robin on ties)
// ENG   | issuing an engine burst, one word per unstalled, unyielded cycle
// CSR   | issuing one CSR read word
module cr_prefix_attach_mem_arb #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 64,
   parameter int RD_LAT  = 1,
   parameter int BURST_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              eng_req,
   input  logic [ADDR_W-1:0] eng_addr,
   input  logic [BURST_W-1:0] eng_len_m1,
   input  logic              eng_stall,
   output logic              eng_ack,
   output logic              eng_dout_valid,
   output logic [DATA_W-1:0] eng_dout,
   output logic              eng_eot,
   input  logic              csr_req,
   input  logic [ADDR_W-1:0] csr_addr,
   output logic              csr_ack,
   output logic              csr_rvalid,
   output logic [DATA_W-1:0] csr_rdata,
   output logic              mem_cs,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dout,
   input  logic              mem_yield,
   output logic              arb_busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_ENG, ST_CSR} state_t;
   localparam logic OWN_CSR = 1'b0;
   localparam logic OWN_ENG = 1'b1;

   state_t              state_q, state_d;
   logic                rr_last_q, rr_last_d;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [BURST_W-1:0]  cnt_q, cnt_d;
   logic                eng_ack_q, eng_ack_d;
   logic                csr_ack_q, csr_ack_d;
   logic [RD_LAT-1:0]   pv_q, pv_d;
   logic [RD_LAT-1:0]   po_q, po_d;
   logic [RD_LAT-1:0]   pl_q, pl_d;
   logic [DATA_W-1:0]   csr_rdata_q, csr_rdata_d;
   logic                csr_rvalid_q, csr_rvalid_d;
   logic                issue, issue_own, issue_last;
   logic                tail_v, csr_take;

   always_comb begin
      state_d    = state_q;
      rr_last_d  = rr_last_q;
      cur_addr_d = cur_addr_q;
      cnt_d      = cnt_q;
      eng_ack_d  = 1'b0;
      csr_ack_d  = 1'b0;
      issue      = 1'b0;
      issue_own  = OWN_CSR;
      issue_last = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // rr_last only moves on a true tie; a lone request never changes priority
            if (eng_req && (!csr_req || rr_last_q == OWN_CSR)) begin
               state_d    = ST_ENG;
               cur_addr_d = eng_addr;
               cnt_d      = eng_len_m1;
               eng_ack_d  = 1'b1;
               if (csr_req) rr_last_d = OWN_ENG;
            end else if (csr_req) begin
               state_d    = ST_CSR;
               cur_addr_d = csr_addr;
               csr_ack_d  = 1'b1;
               if (eng_req) rr_last_d = OWN_CSR;
            end
         end
         ST_ENG: begin
            if (!mem_yield && !eng_stall) begin
               issue      = 1'b1;
               issue_own  = OWN_ENG;
               issue_last = (cnt_q == '0);
               cur_addr_d = cur_addr_q + ADDR_W'(1);
               cnt_d      = cnt_q - BURST_W'(1);
               if (cnt_q == '0) state_d = ST_IDLE;
            end
         end
         ST_CSR: begin
            if (!mem_yield) begin
               issue      = 1'b1;
               issue_own  = OWN_CSR;
               issue_last = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pv_d    = '0;
      po_d    = '0;
      pl_d    = '0;
      pv_d[0] = issue;
      po_d[0] = issue_own;
      pl_d[0] = issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
         pv_d[i] = pv_q[i-1];
         po_d[i] = po_q[i-1];
         pl_d[i] = pl_q[i-1];
      end
      tail_v       = pv_q[RD_LAT-1];
      csr_take     = tail_v && (po_q[RD_LAT-1] == OWN_CSR);
      csr_rdata_d  = csr_take ? mem_dout : csr_rdata_q;
      csr_rvalid_d = csr_take;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rr_last_q    <= OWN_CSR;
         cur_addr_q   <= '0;
         cnt_q        <= '0;
         eng_ack_q    <= 1'b0;
         csr_ack_q    <= 1'b0;
         pv_q         <= '0;
         po_q         <= '0;
         pl_q         <= '0;
         csr_rdata_q  <= '0;
         csr_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_last_q    <= rr_last_d;
         cur_addr_q   <= cur_addr_d;
         cnt_q        <= cnt_d;
         eng_ack_q    <= eng_ack_d;
         csr_ack_q    <= csr_ack_d;
         pv_q         <= pv_d;
         po_q         <= po_d;
         pl_q         <= pl_d;
         csr_rdata_q  <= csr_rdata_d;
         csr_rvalid_q <= csr_rvalid_d;
      end
   end

   assign mem_cs         = issue;
   assign mem_addr       = issue ? cur_addr_q : '0;
   assign eng_ack        = eng_ack_q;
   assign csr_ack        = csr_ack_q;
   assign eng_dout_valid = tail_v && (po_q[RD_LAT-1] == OWN_ENG);
   assign eng_eot        = eng_dout_valid && pl_q[RD_LAT-1];
   assign eng_dout       = eng_dout_valid ? mem_dout : '0;
   assign csr_rvalid     = csr_rvalid_q;
   assign csr_rdata      = csr_rdata_q;
   assign arb_busy       = (state_q != ST_IDLE) || (|pv_q);

endmodule
